resp_scoreboard: RTL and testbench
==================================

RESP_SCOREBOARD -- requirements
Module: resp_scoreboard

Interface
REQ-001 SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge.
  resetn  in  1  asynchronous, active-low reset.
  id_valid  in  1  ID stage holds a valid instruction.
  id_rj_no, id_rk_no  in  Gr  ID source register numbers.
  id_rj_used, id_rk_used  in  1  source operand actually read.
  id_we  in  1  ID instruction writes a register.
  id_rd_no  in  Gr  ID destination register.
  id_is_load  in  1  ID instruction is a load; result unavailable before WB.
  ex_kill  in  1  instruction in EX squashed this cycle.
  ex_kill_rd_no  in  Gr  destination of the squashed instruction.
  wb_we  in  1  WB commits a register write this cycle.
  wb_rd_no  in  Gr  WB destination register.
  wb_is_load  in  1  WB write is load data.
  stall_id  out  1  hold ID; block issue this cycle.
  issue  out  1  ID instruction issues into EX this cycle.
  load_pend  out  32  per-register unresolved-load flag.
  sb_err  out  1  sticky protocol error.
  stall_cnt  out  32  stall-cycle counter (RESP_SB_STAT_EN only).

Function
REQ-002 SHALL keep per register r (1..31) a 2-bit in-flight write count cnt[r] and a load flag ld[r]; r0 SHALL never be tracked, stall, or flag.
REQ-003 SHALL assert stall_id combinationally when id_valid and either used source r has ld[r]=1, or id_we with id_rd_no!=0 and cnt[id_rd_no]=3.
REQ-004 SHALL drive issue = id_valid && !stall_id.
REQ-005 On issue with id_we and id_rd_no!=0: cnt +1; ld set if id_is_load.
REQ-006 On wb_we with wb_rd_no!=0: cnt -1; ld cleared if wb_is_load.
REQ-007 On ex_kill with ex_kill_rd_no!=0: cnt -1; ld cleared.
REQ-008 Same-cycle events on one register SHALL sum: issue+retire leaves cnt unchanged; set of ld SHALL win over clear in the same cycle.
REQ-009 A decrement at cnt=0 or an increment at cnt=3 SHALL leave cnt unchanged and set sb_err, which holds until reset.
REQ-010 Non-load producers SHALL never cause stall_id; their results are covered by MEM/WB forwarding.
REQ-011 load_pend SHALL equal ld[] from registers, bit 0 constant 0, one cycle after the causing edge.

Reset
REQ-012 resetn low SHALL immediately clear all cnt, all ld, sb_err and stall_cnt to 0; stall_id and issue then follow REQ-003/004 from the zeroed state.
REQ-013 Reset deassertion mid-program SHALL need no flush; the first post-reset issue is tracked normally.

Configuration
REQ-014 With RESP_SB_STAT_EN defined: stall_cnt +1 per cycle with stall_id=1, wrapping at 2^32.
REQ-015 Without RESP_SB_STAT_EN: stall_cnt SHALL be constant 0, with no counter flops.

Structure
REQ-016 Gr, DType and the constants SB_CNT_W=2 and SB_CNT_MAX=3 SHALL live in cpuDefine.
REQ-017 The per-register counter and flag SHALL be one sub-module, sb_entry, instantiated 31 times.

Verification
REQ-018 Load to r5 issues, next ID reads r5 -> stall_id=1 until wb_we/wb_is_load on r5; issue=1 the following cycle.
REQ-019 ADD to r7, next ID reads r7 -> stall_id=0, cnt[7]=1, returning to 0 at WB.
REQ-020 Three issues to r9 with no WB -> fourth writer to r9 stalls; one WB on r9 -> writer issues, cnt[9]=3.
REQ-021 Load r4 issues while ex_kill on r4 in the same cycle -> cnt unchanged, ld[4]=1.
REQ-022 wb_we on r3 with cnt[3]=0 -> sb_err=1 and held; writes to r0 -> no state change.
REQ-023 resetn low with ld[5]=1 and cnt[9]=2 -> all state 0 immediately; with RESP_SB_STAT_EN, 4 stall cycles -> stall_cnt=4.

Source files
------------

// File: rtl/cpuDefine.sv
// rtl/cpuDefine.sv - shared register-number, data types and scoreboard constants
package cpuDefine;

    typedef logic [4:0]  Gr;
    typedef logic [31:0] DType;

    localparam int SB_CNT_W = 2;
    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = 2'd3;
    localparam int NUM_REGS = 32;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/resp_scoreboard_if.sv
// rtl/resp_scoreboard_if.sv - pipeline-to-scoreboard signal bundle with modports
interface resp_scoreboard_if;
    import cpuDefine::*;

    logic id_valid;
    Gr    id_rj_no;
    Gr    id_rk_no;
    logic id_rj_used;
    logic id_rk_used;
    logic id_we;
    Gr    id_rd_no;
    logic id_is_load;
    logic ex_kill;
    Gr    ex_kill_rd_no;
    logic wb_we;
    Gr    wb_rd_no;
    logic wb_is_load;
    logic stall_id;
    logic issue;
    DType load_pend;
    logic sb_err;
    DType stall_cnt;

    modport master (
        output id_valid, id_rj_no, id_rk_no, id_rj_used, id_rk_used,
        output id_we, id_rd_no, id_is_load, ex_kill, ex_kill_rd_no,
        output wb_we, wb_rd_no, wb_is_load,
        input  stall_id, issue, load_pend, sb_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_rj_no, id_rk_no, id_rj_used, id_rk_used,
        input  id_we, id_rd_no, id_is_load, ex_kill, ex_kill_rd_no,
        input  wb_we, wb_rd_no, wb_is_load,
        output stall_id, issue, load_pend, sb_err, stall_cnt
    );

endinterface

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one register's in-flight write counter and unresolved-load flag
module sb_entry
    import cpuDefine::*;
(
    input  logic    clk,
    input  logic    resetn,
    input  logic    inc,
    input  logic    dec_wb,
    input  logic    dec_kill,
    input  logic    ld_set,
    input  logic    ld_clr,
    output sb_cnt_t cnt,
    output logic    ld,
    output logic    ovf
);

    logic [SB_CNT_W:0] up;
    logic [SB_CNT_W:0] down;
    logic [SB_CNT_W:0] diff;
    sb_cnt_t           cnt_nxt;

    // Net all same-cycle events; an out-of-range result keeps the count and flags it.
    always_comb begin
        up      = {1'b0, cnt} + {{SB_CNT_W{1'b0}}, inc};
        down    = {{SB_CNT_W{1'b0}}, dec_wb} + {{SB_CNT_W{1'b0}}, dec_kill};
        diff    = up - down;
        ovf     = 1'b0;
        cnt_nxt = cnt;
        if (up < down) begin
            ovf = 1'b1;
        end else if (diff > {1'b0, SB_CNT_MAX}) begin
            ovf = 1'b1;
        end else begin
            cnt_nxt = diff[SB_CNT_W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Load flag: a new load issuing wins over a same-cycle retire or kill.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld <= 1'b0;
        end else if (ld_set) begin
            ld <= 1'b1;
        end else if (ld_clr) begin
            ld <= 1'b0;
        end
    end

endmodule

// File: rtl/resp_scoreboard.sv
// rtl/resp_scoreboard.sv - load-use scoreboard; optional stall counter under RESP_SB_STAT_EN
module resp_scoreboard
    import cpuDefine::*;
(
    input  logic               clk,
    input  logic               resetn,
    resp_scoreboard_if.slave   bus
);

    logic [NUM_REGS-1:0]               ld_vec;
    logic [NUM_REGS-1:0]               ovf_vec;
    logic [NUM_REGS-1:0][SB_CNT_W-1:0] cnt_vec;
    logic                              rj_hit;
    logic                              rk_hit;
    logic                              wr_full;
    logic                              stall;
    logic                              issue;
    logic                              sb_err_q;

    // r0 is hardwired and never tracked.
    assign ld_vec[0]  = 1'b0;
    assign ovf_vec[0] = 1'b0;
    assign cnt_vec[0] = '0;

    // Only unresolved loads and a saturated writer count hold ID; ALU results are forwarded.
    always_comb begin
        rj_hit  = bus.id_rj_used && (bus.id_rj_no != '0) && ld_vec[bus.id_rj_no];
        rk_hit  = bus.id_rk_used && (bus.id_rk_no != '0) && ld_vec[bus.id_rk_no];
        wr_full = bus.id_we && (bus.id_rd_no != '0) && (cnt_vec[bus.id_rd_no] == SB_CNT_MAX);
        stall   = bus.id_valid && (rj_hit || rk_hit || wr_full);
        issue   = bus.id_valid && !stall;
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic inc;
        logic dec_wb;
        logic dec_kill;
        logic ld_set;
        logic ld_clr;

        assign inc      = issue && bus.id_we && (bus.id_rd_no == Gr'(r));
        assign ld_set   = inc && bus.id_is_load;
        assign dec_wb   = bus.wb_we && (bus.wb_rd_no == Gr'(r));
        assign dec_kill = bus.ex_kill && (bus.ex_kill_rd_no == Gr'(r));
        assign ld_clr   = (dec_wb && bus.wb_is_load) || dec_kill;

        sb_entry u_entry (
            .clk      (clk),
            .resetn   (resetn),
            .inc      (inc),
            .dec_wb   (dec_wb),
            .dec_kill (dec_kill),
            .ld_set   (ld_set),
            .ld_clr   (ld_clr),
            .cnt      (cnt_vec[r]),
            .ld       (ld_vec[r]),
            .ovf      (ovf_vec[r])
        );
    end

    // Sticky protocol error: any counter over/underflow latches until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err_q <= 1'b0;
        end else if (|ovf_vec) begin
            sb_err_q <= 1'b1;
        end
    end

    assign bus.stall_id  = stall;
    assign bus.issue     = issue;
    assign bus.load_pend = ld_vec;
    assign bus.sb_err    = sb_err_q;

`ifdef RESP_SB_STAT_EN
    DType stall_cnt_q;

    // Free-running count of stalled ID cycles, wrapping naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_resp_scoreboard.sv
// tb/tb_resp_scoreboard.sv - directed scoreboard bench; stall_cnt expectation follows RESP_SB_STAT_EN
module tb_resp_scoreboard;
    import cpuDefine::*;

`ifdef RESP_SB_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic        stall;
        logic        issue;
        logic [31:0] lp;
        logic        err;
        int          creg;
        logic [1:0]  ccnt;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_stalls = 0;
    exp_t q[$];

    resp_scoreboard_if bus ();

    resp_scoreboard dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic idle();
        bus.id_valid = 0; bus.id_rj_no = 0; bus.id_rj_used = 0;
        bus.id_rk_no = 0; bus.id_rk_used = 0; bus.id_we = 0;
        bus.id_rd_no = 0; bus.id_is_load = 0;
        bus.ex_kill = 0; bus.ex_kill_rd_no = 0;
        bus.wb_we = 0; bus.wb_rd_no = 0; bus.wb_is_load = 0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rj, input logic rju, input logic [4:0] rk,
                            input logic rku, input logic we, input logic [4:0] rd, input logic ld);
        bus.id_valid = v; bus.id_rj_no = rj; bus.id_rj_used = rju;
        bus.id_rk_no = rk; bus.id_rk_used = rku; bus.id_we = we;
        bus.id_rd_no = rd; bus.id_is_load = ld;
    endtask

    task automatic drive_wb(input logic [4:0] rd, input logic ld);
        bus.wb_we = 1; bus.wb_rd_no = rd; bus.wb_is_load = ld;
    endtask

    task automatic drive_kill(input logic [4:0] rd);
        bus.ex_kill = 1; bus.ex_kill_rd_no = rd;
    endtask

    task automatic push(input string tag, input logic st, input logic is, input logic [31:0] lp,
                        input logic er, input int creg, input logic [1:0] cc);
        exp_t e;
        e.tag = tag; e.stall = st; e.issue = is; e.lp = lp;
        e.err = er; e.creg = creg; e.ccnt = cc;
        q.push_back(e);
    endtask

    task automatic compare_now();
        exp_t e;
        n_vec++;
        assert (q.size() != 0) else begin
            n_err++;
            $error("FAIL queue observed=empty expected=entry");
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            cmp(e.tag, "stall_id",  {31'b0, bus.stall_id}, {31'b0, e.stall});
            cmp(e.tag, "issue",     {31'b0, bus.issue},    {31'b0, e.issue});
            cmp(e.tag, "load_pend", bus.load_pend,         e.lp);
            cmp(e.tag, "sb_err",    {31'b0, bus.sb_err},   {31'b0, e.err});
            cmp(e.tag, "cnt",       {30'b0, dut.cnt_vec[e.creg]}, {30'b0, e.ccnt});
            cmp(e.tag, "stall_cnt", bus.stall_cnt,         STAT ? 32'(exp_stalls) : 32'd0);
            if (e.stall && resetn) exp_stalls++;
        end
    endtask

    task automatic check();
        @(negedge clk);
        compare_now();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        push("reset_state", 0, 0, 32'h0, 0, 5, 0); check();
        resetn = 1'b1;

        // load-use on r5
        drive_id(1, 0, 0, 0, 0, 1, 5, 1); push("r5_load_issue", 0, 1, 32'h0, 0, 5, 0); check();
        drive_id(1, 5, 1, 0, 0, 1, 6, 0); push("r5_stall_a", 1, 0, 32'h20, 0, 5, 1); check();
        drive_id(1, 5, 1, 0, 0, 1, 6, 0); push("r5_stall_b", 1, 0, 32'h20, 0, 5, 1); check();
        drive_id(1, 5, 1, 0, 0, 1, 6, 0); drive_wb(5, 1);
        push("r5_stall_wb", 1, 0, 32'h20, 0, 5, 1); check();
        drive_id(1, 5, 1, 0, 0, 1, 6, 0); push("r5_release", 0, 1, 32'h0, 0, 5, 0); check();

        // ALU producer never stalls
        drive_id(1, 0, 0, 0, 0, 1, 7, 0); push("r7_add_issue", 0, 1, 32'h0, 0, 7, 0); check();
        drive_id(1, 7, 1, 6, 1, 0, 0, 0); drive_wb(6, 0);
        push("r7_read_nostall", 0, 1, 32'h0, 0, 7, 1); check();
        drive_wb(7, 0); push("r7_wb_pending", 0, 0, 32'h0, 0, 7, 1); check();
        push("r7_cnt_zero", 0, 0, 32'h0, 0, 7, 0); check();

        // writer-count saturation on r9
        drive_id(1, 0, 0, 0, 0, 1, 9, 0); push("r9_w1", 0, 1, 32'h0, 0, 9, 0); check();
        drive_id(1, 0, 0, 0, 0, 1, 9, 0); push("r9_w2", 0, 1, 32'h0, 0, 9, 1); check();
        drive_id(1, 0, 0, 0, 0, 1, 9, 0); push("r9_w3", 0, 1, 32'h0, 0, 9, 2); check();
        drive_id(1, 0, 0, 0, 0, 1, 9, 0); push("r9_w4_stall", 1, 0, 32'h0, 0, 9, 3); check();
        drive_id(1, 0, 0, 0, 0, 1, 9, 0); drive_wb(9, 0);
        push("r9_stall_wb", 1, 0, 32'h0, 0, 9, 3); check();
        drive_id(1, 0, 0, 0, 0, 1, 9, 0); push("r9_w4_issue", 0, 1, 32'h0, 0, 9, 2); check();
        push("r9_cnt_full", 0, 0, 32'h0, 0, 9, 3); check();

        // load issue and kill on r4 in one cycle
        drive_id(1, 0, 0, 0, 0, 1, 4, 1); drive_kill(4);
        push("r4_issue_kill", 0, 1, 32'h0, 0, 4, 0); check();
        push("r4_ld_set", 0, 0, 32'h10, 0, 4, 0); check();

        // r0 is inert; unused source does not stall
        drive_id(1, 0, 1, 0, 1, 1, 0, 1); drive_wb(0, 1); drive_kill(0);
        push("r0_ops", 0, 1, 32'h10, 0, 0, 0); check();
        push("r0_nochange", 0, 0, 32'h10, 0, 0, 0); check();
        drive_id(1, 4, 0, 0, 1, 0, 0, 0); push("r4_unused_src", 0, 1, 32'h10, 0, 4, 0); check();

        // underflow on r3 sets sticky error
        drive_wb(3, 0); push("r3_wb_underflow", 0, 0, 32'h10, 0, 3, 0); check();
        push("r3_err_set", 0, 0, 32'h10, 1, 3, 0); check();
        push("r3_err_held", 0, 0, 32'h10, 1, 3, 0); check();

        // mid-program asynchronous reset
        drive_id(1, 0, 0, 0, 0, 1, 5, 1); drive_wb(9, 0);
        push("rst_setup", 0, 1, 32'h10, 1, 9, 3); check();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0); push("rst_pre", 1, 0, 32'h30, 1, 9, 2); check();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        exp_stalls = 0;
        #1;
        push("rst_async_r9", 0, 1, 32'h0, 0, 9, 0); compare_now();
        push("rst_async_r5", 0, 1, 32'h0, 0, 5, 0); compare_now();
        @(posedge clk);
        #1;
        idle();
        resetn = 1'b1;

        // first post-reset issue tracked normally; four stall cycles
        drive_id(1, 0, 0, 0, 0, 1, 5, 1); push("post_first_issue", 0, 1, 32'h0, 0, 5, 0); check();
        for (int k = 0; k < 4; k++) begin
            drive_id(1, 5, 1, 0, 0, 0, 0, 0);
            push($sformatf("post_stall_%0d", k), 1, 0, 32'h20, 0, 5, 1); check();
        end
        drive_wb(5, 1); push("post_wb", 0, 0, 32'h20, 0, 5, 1); check();
        push("post_final", 0, 0, 32'h0, 0, 5, 0); check();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
